mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory access controller sitting between a CPU datapath and a simple
//   request/acknowledge memory port. Holds the address (MAR) and data (MDR)
//   registers, sequences one read or write per command, and aborts an access
//   that does not see mem_ack within TIMEOUT wait cycles.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   clr        in   1   synchronous active-high reset
//   BusMuxOut  in  32   datapath bus value
//   MARin      in   1   load MAR from BusMuxOut[8:0] (IDLE only)
//   MDRin      in   1   load MDR from BusMuxOut (IDLE only)
//   Read       in   1   start a read at MAR (wins over Write)
//   Write      in   1   start a write of MDR at MAR
//   mem_rdata  in  32   memory read data, valid with mem_ack
//   mem_ack    in   1   memory completion strobe
//   mem_addr   out  9   MAR contents
//   mem_wdata  out 32   MDR contents
//   mem_rd     out  1   high exactly while waiting on a read
//   mem_wr     out  1   high exactly while waiting on a write
//   MDR_Q      out 32   MDR contents to the datapath
//   MFC        out  1   memory function complete, one-cycle pulse
//   busy       out  1   high whenever the controller is not idle
//   err        out  1   sticky timeout flag, cleared only by clr
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] BusMuxOut,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] MDR_Q,
  output logic        MFC,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q;
  logic [8:0]  mar_q;
  logic [31:0] mdr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        rd_q, wr_q, mfc_q, busy_q, err_q;
  logic        limit_hit;

  // The wait cycle in progress is the one that brings the counter to TIMEOUT.
  assign cnt_d     = cnt_q + 8'd1;
  assign limit_hit = (cnt_d == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mfc_q <= 1'b0;
          cnt_q <= '0;
          // Register loads land on the same edge the command is accepted,
          // so the access uses the freshly loaded address/data.
          if (MARin) mar_q <= BusMuxOut[8:0];
          if (MDRin) mdr_q <= BusMuxOut;
          if (Read) begin
            state_q <= RD_WAIT;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (Write) begin
            state_q <= WR_WAIT;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          // An ack on the limit cycle still completes the access cleanly.
          if (mem_ack) begin
            if (state_q == RD_WAIT) mdr_q <= mem_rdata;
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mfc_q   <= 1'b1;
          end else if (limit_hit) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mfc_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          mfc_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          mfc_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign MDR_Q     = mdr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign MFC       = mfc_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl, instantiated with TIMEOUT=4.
// Directed table of per-cycle vectors, a hand-written write-timeout and
// ack-on-limit sequence, then randomized traffic against a transaction-level
// reference model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        clr, MARin, MDRin, Read, Write, mem_ack;
  logic [31:0] BusMuxOut, mem_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, MDR_Q;
  logic        mem_rd, mem_wr, MFC, busy, err;

  int n_vec = 0;
  int n_bad = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .MDR_Q(MDR_Q), .MFC(MFC), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Packed observation: addr, wdata, rd, wr, mdr, mfc, busy, err
  function automatic logic [77:0] pk(input logic [8:0] a, input logic [31:0] wd,
                                     input logic r, input logic w, input logic [31:0] m,
                                     input logic f, input logic b, input logic e);
    return {a, wd, r, w, m, f, b, e};
  endfunction

  // Expected state after a step: MDR drives both mem_wdata and MDR_Q.
  function automatic logic [77:0] ex(input logic [8:0] a, input logic [31:0] m,
                                     input logic r, input logic w,
                                     input logic f, input logic b, input logic e);
    return pk(a, m, r, w, m, f, b, e);
  endfunction

  typedef struct {
    logic        clr;
    logic [31:0] bus;
    logic        marin, mdrin, rd, wr;
    logic [31:0] rdata;
    logic        ack;
    logic [77:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic [31:0] bus, input logic ma,
                              input logic md, input logic r, input logic w,
                              input logic [31:0] rdat, input logic ack, input logic [77:0] e);
    vec_t v;
    v.clr = c; v.bus = bus; v.marin = ma; v.mdrin = md; v.rd = r; v.wr = w;
    v.rdata = rdat; v.ack = ack; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic c, input logic [31:0] bus, input logic ma, input logic md,
                       input logic r, input logic w, input logic [31:0] rdat, input logic ack);
    clr = c; BusMuxOut = bus; MARin = ma; MDRin = md; Read = r; Write = w;
    mem_rdata = rdat; mem_ack = ack;
  endtask

  task automatic check(input string name, input logic [77:0] exp);
    logic [77:0] act;
    act = pk(mem_addr, mem_wdata, mem_rd, mem_wr, MDR_Q, MFC, busy, err);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr=%h wdata=%h rd=%b wr=%b mdr=%h mfc=%b busy=%b err=%b, want addr=%h wdata=%h rd=%b wr=%b mdr=%h mfc=%b busy=%b err=%b",
               name, act[77:69], act[68:37], act[36], act[35], act[34:3], act[2], act[1], act[0],
               exp[77:69], exp[68:37], exp[36], exp[35], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference model: tracks the pending operation and the number of cycles
  // it has waited; completion occupies one cycle after the access ends.
  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  logic        m_err, m_fin;
  int          m_op;      // 0 none, 1 read, 2 write
  int          m_waited;

  task automatic model_step(input logic c, input logic [31:0] bus, input logic ma,
                            input logic md, input logic r, input logic w,
                            input logic [31:0] rdat, input logic ack);
    if (c) begin
      m_mar = '0; m_mdr = '0; m_err = 1'b0; m_fin = 1'b0; m_op = 0; m_waited = 0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_op != 0) begin
      if (ack) begin
        if (m_op == 1) m_mdr = rdat;
        m_op = 0; m_fin = 1'b1;
      end else begin
        m_waited++;
        if (m_waited == TO) begin
          m_err = 1'b1; m_op = 0; m_fin = 1'b1;
        end
      end
    end else begin
      if (ma) m_mar = bus[8:0];
      if (md) m_mdr = bus;
      m_waited = 0;
      if (r) m_op = 1;
      else if (w) m_op = 2;
    end
  endtask

  function automatic logic [77:0] model_exp();
    return ex(m_mar, m_mdr, m_op == 1, m_op == 2, m_fin, (m_op != 0) || m_fin, m_err);
  endfunction

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Directed table: inputs for one cycle, expected outputs after its edge.
    // Reset
    tbl.push_back(mk(1, 0, 0,0,0,0, 0, 0, ex(9'h000, 32'h0, 0,0,0,0,0)));
    // Read at 0x045, ack on wait cycle 3
    tbl.push_back(mk(0, 32'h45, 1,0,1,0, 0, 0, ex(9'h045, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h045, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h045, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 32'hDEADBEEF, 1, ex(9'h045, 32'hDEADBEEF, 0,0,1,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h045, 32'hDEADBEEF, 0,0,0,0,0)));
    // Write 0x12345678 to 0x1FF, ack on first wait cycle; rdata ignored
    tbl.push_back(mk(0, 32'h12345678, 0,1,0,0, 0, 0, ex(9'h045, 32'h12345678, 0,0,0,0,0)));
    tbl.push_back(mk(0, 32'h1FF, 1,0,0,1, 0, 0, ex(9'h1FF, 32'h12345678, 0,1,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 32'hFFFFFFFF, 1, ex(9'h1FF, 32'h12345678, 0,0,1,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h1FF, 32'h12345678, 0,0,0,0,0)));
    // Read with no ack: times out after 4 wait cycles
    tbl.push_back(mk(0, 0, 0,0,1,0, 0, 0, ex(9'h1FF, 32'h12345678, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h1FF, 32'h12345678, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h1FF, 32'h12345678, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h1FF, 32'h12345678, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h1FF, 32'h12345678, 0,0,1,1,1)));
    // Read during DONE is dropped
    tbl.push_back(mk(0, 0, 0,0,1,0, 0, 0, ex(9'h1FF, 32'h12345678, 0,0,0,0,1)));
    // Second read succeeds, err stays set
    tbl.push_back(mk(0, 0, 0,0,1,0, 0, 0, ex(9'h1FF, 32'h12345678, 1,0,0,1,1)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 32'hCAFEF00D, 1, ex(9'h1FF, 32'hCAFEF00D, 0,0,1,1,1)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h1FF, 32'hCAFEF00D, 0,0,0,0,1)));
    tbl.push_back(mk(1, 32'h77, 1,1,1,1, 32'h1, 1, ex(9'h000, 32'h0, 0,0,0,0,0)));
    // Read and Write together: read wins; loads and Write mid-wait ignored
    tbl.push_back(mk(0, 32'h33, 1,0,1,1, 0, 0, ex(9'h033, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,1, 0, 0, ex(9'h033, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 32'hAA, 1,1,0,0, 0, 0, ex(9'h033, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 32'h55, 1, ex(9'h033, 32'h55, 0,0,1,1,0)));
    tbl.push_back(mk(0, 32'h100, 1,1,0,0, 0, 0, ex(9'h033, 32'h55, 0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h033, 32'h55, 0,0,0,0,0)));
    // clr on wait cycle 2, late ack ignored
    tbl.push_back(mk(0, 0, 0,0,1,0, 0, 0, ex(9'h033, 32'h55, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h033, 32'h55, 1,0,0,1,0)));
    tbl.push_back(mk(1, 0, 0,0,0,0, 0, 0, ex(9'h000, 32'h0, 0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 32'h77, 1, ex(9'h000, 32'h0, 0,0,0,0,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h000, 32'h0, 0,0,0,0,0)));
    // clr overrides a Read; command accepted on the first edge after release
    tbl.push_back(mk(1, 32'h0F0, 1,0,1,0, 0, 0, ex(9'h000, 32'h0, 0,0,0,0,0)));
    tbl.push_back(mk(0, 32'h0F0, 1,0,1,0, 0, 0, ex(9'h0F0, 32'h0, 1,0,0,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 32'h9, 1, ex(9'h0F0, 32'h9, 0,0,1,1,0)));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, ex(9'h0F0, 32'h9, 0,0,0,0,0)));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].bus, tbl[i].marin, tbl[i].mdrin, tbl[i].rd, tbl[i].wr,
            tbl[i].rdata, tbl[i].ack);
      @(posedge clk); #1;
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // Write timeout: mem_wr for 4 cycles, then err + MFC, MDR untouched
    drive(0, 32'hA5A5A5A5, 0,1,0,1, 0, 0);
    @(posedge clk); #1; check("wto_issue", ex(9'h0F0, 32'hA5A5A5A5, 0,1,0,1,0));
    drive(0, 0, 0,0,0,0, 0, 0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1; check($sformatf("wto_wait%0d", k), ex(9'h0F0, 32'hA5A5A5A5, 0,1,0,1,0));
    end
    @(posedge clk); #1; check("wto_abort", ex(9'h0F0, 32'hA5A5A5A5, 0,0,1,1,1));
    @(posedge clk); #1; check("wto_idle", ex(9'h0F0, 32'hA5A5A5A5, 0,0,0,0,1));

    // Read with ack arriving on the limit cycle: completes, err unchanged by it
    drive(1, 0, 0,0,0,0, 0, 0);
    @(posedge clk); #1; check("lim_clr", ex(9'h000, 32'h0, 0,0,0,0,0));
    drive(0, 32'h1AB, 1,0,1,0, 0, 0);
    @(posedge clk); #1; check("lim_issue", ex(9'h1AB, 32'h0, 1,0,0,1,0));
    drive(0, 0, 0,0,0,0, 0, 0);
    repeat (3) @(posedge clk);
    #1; check("lim_wait4", ex(9'h1AB, 32'h0, 1,0,0,1,0));
    drive(0, 0, 0,0,0,0, 32'h600DF00D, 1);
    @(posedge clk); #1; check("lim_ack", ex(9'h1AB, 32'h600DF00D, 0,0,1,1,0));
    drive(0, 0, 0,0,0,0, 0, 0);
    @(posedge clk); #1; check("lim_idle", ex(9'h1AB, 32'h600DF00D, 0,0,0,0,0));

    // Randomized traffic against the reference model
    begin
      logic        c, ma, md, r, w, a;
      logic [31:0] bus, rdat;
      for (int i = 0; i < 600; i++) begin
        c    = (i == 0) || ($urandom_range(0, 49) == 0);
        bus  = $urandom;
        ma   = $urandom_range(0, 2) == 0;
        md   = $urandom_range(0, 2) == 0;
        r    = $urandom_range(0, 2) == 0;
        w    = $urandom_range(0, 2) == 0;
        rdat = $urandom;
        a    = $urandom_range(0, 4) == 0;
        drive(c, bus, ma, md, r, w, rdat, a);
        @(posedge clk);
        model_step(c, bus, ma, md, r, w, rdat, a);
        #1; check($sformatf("rnd[%0d]", i), model_exp());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
